// File: rtl/debounce_bank.sv
// debounce_bank: per-channel 2-flop sync, stability filter, edge pulses, priority encode.
// Define DEBOUNCE_BANK_REPEAT_EN to add held-button auto-repeat pulses on rpt.
module debounce_bank #(
  parameter int N_CH            = 6,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  localparam int IDXW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] rpt,
  output logic            any_active,
  output logic [IDXW-1:0] active_idx,
  output logic [N_CH-1:0] active_oh
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0] s1_q, s2_q;
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] rise_q, rise_d;
  logic [N_CH-1:0] fall_q, fall_d;
  logic [N_CH-1:0] acc_w;

  // Any agreeing sample restarts the count, so short glitches never land.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc;

    always_comb begin
      cnt_d = cnt_q;
      acc   = 1'b0;
      if (s2_q[i] == level_q[i]) begin
        cnt_d = '0;
      end else if (cnt_q == CntLast) begin
        cnt_d = '0;
        acc   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign acc_w[i] = acc;
  end

  assign level_d = level_q ^ acc_w;
  assign rise_d  = acc_w & ~level_q;
  assign fall_d  = acc_w & level_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      s1_q    <= raw_in;
      s2_q    <= s1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DlyLast = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PerLast = RW'(REPEAT_PERIOD - 1);

  logic [N_CH-1:0] rpt_q;
  logic [N_CH-1:0] fire_w;

  // arm_q selects the first-repeat delay versus the steady repeat period.
  for (genvar i = 0; i < N_CH; i++) begin : g_rpt
    logic [RW-1:0] rc_q, rc_d;
    logic          arm_q, arm_d;
    logic          fire;

    always_comb begin
      rc_d  = rc_q;
      arm_d = arm_q;
      fire  = 1'b0;
      if (!level_q[i] || fall_d[i]) begin
        rc_d  = '0;
        arm_d = 1'b0;
      end else if (rc_q == (arm_q ? PerLast : DlyLast)) begin
        rc_d  = '0;
        arm_d = 1'b1;
        fire  = 1'b1;
      end else begin
        rc_d = rc_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rc_q  <= '0;
        arm_q <= 1'b0;
      end else begin
        rc_q  <= rc_d;
        arm_q <= arm_d;
      end
    end

    assign fire_w[i] = fire;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= fire_w;
    end
  end

  assign rpt = rpt_q;
`else
  assign rpt = '0;
`endif

  logic [IDXW-1:0] idx_c;
  logic [N_CH-1:0] oh_c;

  always_comb begin
    idx_c = '0;
    oh_c  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (level_q[i]) begin
        idx_c    = IDXW'(i);
        oh_c     = '0;
        oh_c[i]  = 1'b1;
      end
    end
  end

  assign level      = level_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign any_active = |level_q;
  assign active_idx = idx_c;
  assign active_oh  = oh_c;

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed vectors; expected outputs queued per cycle, checked by a monitor.
// Build with DEBOUNCE_BANK_REPEAT_EN to also expect auto-repeat pulses.
module tb_debounce_bank;

`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw_in;
  logic [3:0] level, rise, fall, rpt, active_oh;
  logic       any_active;
  logic [1:0] active_idx;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    int         cyc;
    logic [3:0] lv;
    logic [3:0] rs;
    logic [3:0] fl;
    logic [3:0] rp;
    logic       any;
    logic [1:0] idx;
    logic [3:0] oh;
  } exp_t;

  exp_t exp_q[$];

  debounce_bank #(
    .N_CH(4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .raw_in(raw_in),
    .level(level),
    .rise(rise),
    .fall(fall),
    .rpt(rpt),
    .any_active(any_active),
    .active_idx(active_idx),
    .active_oh(active_oh)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void ex(int c, logic [3:0] lv, logic [3:0] rs,
                             logic [3:0] fl, logic [3:0] rp,
                             logic [1:0] idx, logic [3:0] oh);
    exp_t e;
    e.cyc = c;
    e.lv  = lv;
    e.rs  = rs;
    e.fl  = fl;
    e.rp  = rp;
    e.any = (lv != 4'h0);
    e.idx = idx;
    e.oh  = oh;
    exp_q.push_back(e);
  endfunction

  task automatic goto(int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: pop every entry due this cycle; otherwise no pulse may appear.
  exp_t        m_e;
  logic [22:0] m_act, m_want;
  bit          m_hit;

  always @(negedge clk) begin
    m_hit = 1'b0;
    m_act = {level, rise, fall, rpt, any_active, active_idx, active_oh};
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      m_e    = exp_q.pop_front();
      m_want = {m_e.lv, m_e.rs, m_e.fl, m_e.rp, m_e.any, m_e.idx, m_e.oh};
      m_hit  = 1'b1;
      n_chk++;
      if (m_e.cyc != cyc) begin
        n_fail++;
        $display("FAIL missed_check cyc=%0d got cyc %0d want cyc %0d",
                 cyc, cyc, m_e.cyc);
      end else if (m_act !== m_want) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got lv=%h rs=%h fl=%h rp=%h any=%b idx=%0d oh=%h want lv=%h rs=%h fl=%h rp=%h any=%b idx=%0d oh=%h",
                 cyc, level, rise, fall, rpt, any_active, active_idx, active_oh,
                 m_e.lv, m_e.rs, m_e.fl, m_e.rp, m_e.any, m_e.idx, m_e.oh);
      end
    end
    if (!m_hit) begin
      n_chk++;
      if ({rise, fall, rpt} !== 12'h000) begin
        n_fail++;
        $display("FAIL stray_pulse cyc=%0d got rs=%h fl=%h rp=%h want all 0",
                 cyc, rise, fall, rpt);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog got cyc=%0d want finish by 135", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r1, r2;
    r1 = REP ? 4'b0001 : 4'b0000;
    r2 = REP ? 4'b0010 : 4'b0000;

    // Reset with all inputs high, then release.
    rst_n  = 1'b0;
    raw_in = 4'hF;
    ex(1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 4'h0);
    ex(2, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 4'h0);
    goto(2);
    rst_n = 1'b1;
    ex(7, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 4'h0);
    ex(8, 4'hF, 4'hF, 4'h0, 4'h0, 2'd3, 4'h8);
    ex(9, 4'hF, 4'h0, 4'h0, 4'h0, 2'd3, 4'h8);
    goto(9);
    raw_in = 4'h0;
    ex(14, 4'hF, 4'h0, 4'h0, 4'h0, 2'd3, 4'h8);
    ex(15, 4'h0, 4'h0, 4'hF, 4'h0, 2'd0, 4'h0);

    // Three-cycle glitch on ch0 must be rejected.
    goto(20);
    raw_in = 4'h1;
    goto(23);
    raw_in = 4'h0;
    ex(27, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 4'h0);
    ex(31, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 4'h0);

    // Press and release ch1.
    goto(32);
    raw_in = 4'h2;
    ex(37, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 4'h0);
    ex(38, 4'h2, 4'h2, 4'h0, 4'h0, 2'd1, 4'h2);
    ex(39, 4'h2, 4'h0, 4'h0, 4'h0, 2'd1, 4'h2);
    goto(40);
    raw_in = 4'h0;
    ex(45, 4'h2, 4'h0, 4'h0, 4'h0, 2'd1, 4'h2);
    ex(46, 4'h0, 4'h0, 4'h2, 4'h0, 2'd0, 4'h0);

    // Bounce on ch2: 1,0 then a solid run of 1.
    goto(50);
    raw_in = 4'h4;
    goto(51);
    raw_in = 4'h0;
    goto(52);
    raw_in = 4'h4;
    ex(57, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 4'h0);
    ex(58, 4'h4, 4'h4, 4'h0, 4'h0, 2'd2, 4'h4);
    goto(60);
    raw_in = 4'h0;
    ex(66, 4'h0, 4'h0, 4'h4, 4'h0, 2'd0, 4'h0);

    // Priority: ch1+ch3, drop ch3, drop all.
    goto(70);
    raw_in = 4'hA;
    ex(76, 4'hA, 4'hA, 4'h0, 4'h0, 2'd3, 4'h8);
    goto(78);
    raw_in = 4'h2;
    ex(84, 4'h2, 4'h0, 4'h8, 4'h0, 2'd1, 4'h2);
    goto(85);
    raw_in = 4'h0;
    ex(86, 4'h2, 4'h0, 4'h0, r2, 2'd1, 4'h2);
    ex(89, 4'h2, 4'h0, 4'h0, r2, 2'd1, 4'h2);
    ex(91, 4'h0, 4'h0, 4'h2, 4'h0, 2'd0, 4'h0);

    // Hold ch0 for auto-repeat; release lands on a would-be repeat cycle.
    goto(95);
    raw_in = 4'h1;
    ex(101, 4'h1, 4'h1, 4'h0, 4'h0, 2'd0, 4'h1);
    ex(110, 4'h1, 4'h0, 4'h0, 4'h0, 2'd0, 4'h1);
    ex(111, 4'h1, 4'h0, 4'h0, r1, 2'd0, 4'h1);
    ex(112, 4'h1, 4'h0, 4'h0, 4'h0, 2'd0, 4'h1);
    ex(114, 4'h1, 4'h0, 4'h0, r1, 2'd0, 4'h1);
    ex(117, 4'h1, 4'h0, 4'h0, r1, 2'd0, 4'h1);
    goto(117);
    raw_in = 4'h0;
    ex(120, 4'h1, 4'h0, 4'h0, r1, 2'd0, 4'h1);
    ex(123, 4'h0, 4'h0, 4'h1, 4'h0, 2'd0, 4'h0);

    goto(135);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got %0d entries left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
